// File: rtl/muldiv_operand_stage.sv
// Operand-conditioning register stage for the RISC-V M-extension mul/div datapath.
// Define MULDIV_FASTPATH_EN to build the trivial-result fast path; otherwise fast_o/fast_res_o are tied to 0.
module muldiv_operand_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            kill_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [2:0]      op_o,
   output logic [XLEN-1:0] abs_a_o,
   output logic [XLEN-1:0] abs_b_o,
   output logic            neg_res_o,
   output logic            div_sel_o,
   output logic [5:0]      status_o,
   output logic            fast_o,
   output logic [XLEN-1:0] fast_res_o
);

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_e;

   localparam logic [XLEN-1:0] ONE_VAL  = {{(XLEN-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ONES_VAL = '1;

   typedef struct packed {
      logic [2:0]      op;
      logic [XLEN-1:0] abs_a;
      logic [XLEN-1:0] abs_b;
      logic            neg_res;
      logic [5:0]      status;
   } payload_t;

   // ------------------------------------------------------------------
   // Operand decode
   // ------------------------------------------------------------------
   op_e             op;
   logic            div_op;
   logic            a_signed;
   logic            b_signed;
   logic            a_neg;
   logic            b_neg;
   logic            a_zero;
   logic            a_one;
   logic            a_m1;
   logic            b_zero;
   logic            b_one;
   logic            b_m1;
   logic            neg_res;
   logic [XLEN-1:0] abs_a;
   logic [XLEN-1:0] abs_b;
   payload_t        nxt;
   payload_t        cur;
   logic            valid_q;
   logic            accept;

   assign op     = op_e'(op_i);
   assign div_op = op_i[2];

   // Div ops: the low funct3 bit selects the unsigned variant; mul ops use the low pair.
   assign a_signed = div_op ? !op_i[0] : (op_i[1:0] != 2'b11);
   assign b_signed = div_op ? !op_i[0] : !op_i[1];

   assign a_neg = a_signed & a_i[XLEN-1];
   assign b_neg = b_signed & b_i[XLEN-1];

   // Two's-complement negate wraps MIN back onto itself, which the datapath expects.
   assign abs_a = a_neg ? (~a_i + ONE_VAL) : a_i;
   assign abs_b = b_neg ? (~b_i + ONE_VAL) : b_i;

   assign a_zero = (a_i == '0);
   assign a_one  = (a_i == ONE_VAL);
   assign a_m1   = a_signed & (a_i == ONES_VAL);
   assign b_zero = (b_i == '0);
   assign b_one  = (b_i == ONE_VAL);
   assign b_m1   = b_signed & (b_i == ONES_VAL);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      neg_res = 1'b0;
      if (div_op && b_zero) begin
         neg_res = 1'b0;
      end else if (op == OP_REM) begin
         neg_res = a_neg;
      end else begin
         neg_res = a_neg ^ b_neg;
      end
   end

   always_comb begin
      nxt         = '0;
      nxt.op      = op_i;
      nxt.abs_a   = abs_a;
      nxt.abs_b   = abs_b;
      nxt.neg_res = neg_res;
      nxt.status  = {b_m1, b_one, b_zero, a_m1, a_one, a_zero};
   end

   // ------------------------------------------------------------------
   // Handshake and main register
   // ------------------------------------------------------------------
   assign in_ready_o = !valid_q | out_ready_i;
   assign accept     = in_valid_i & in_ready_o & !kill_i;

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
      if (reset_i) begin
         valid_q <= 1'b0;
         cur     <= '0;
      end else if (kill_i) begin
         valid_q <= 1'b0;
      end else if (accept) begin
         valid_q <= 1'b1;
         cur     <= nxt;
      end else if (out_ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid_o = valid_q;
   assign op_o        = cur.op;
   assign abs_a_o     = cur.abs_a;
   assign abs_b_o     = cur.abs_b;
   assign neg_res_o   = cur.neg_res;
   assign status_o    = cur.status;
   assign div_sel_o   = cur.op[2];

   // ------------------------------------------------------------------
   // Fast path
   // ------------------------------------------------------------------
`ifdef MULDIV_FASTPATH_EN
   logic            fast_nxt;
   logic [XLEN-1:0] fast_res_nxt;
   logic            fast_q;
   logic [XLEN-1:0] fast_res_q;

   // Ordered priority: divide-by-zero, signed overflow, then mul identities.
   always_comb begin
      fast_nxt     = 1'b0;
      fast_res_nxt = '0;
      if (div_op && b_zero) begin
         fast_nxt     = 1'b1;
         fast_res_nxt = op_i[1] ? a_i : ONES_VAL;
      end else if ((op == OP_DIV || op == OP_REM) && a_i == MIN_VAL && b_m1) begin
         fast_nxt     = 1'b1;
         fast_res_nxt = op_i[1] ? '0 : MIN_VAL;
      end else if (op == OP_MUL) begin
         if (a_zero || b_zero) begin
            fast_nxt     = 1'b1;
            fast_res_nxt = '0;
         end else if (b_one) begin
            fast_nxt     = 1'b1;
            fast_res_nxt = a_i;
         end else if (a_one) begin
            fast_nxt     = 1'b1;
            fast_res_nxt = b_i;
         end
      end else if (!div_op && (a_zero || b_zero)) begin
         fast_nxt     = 1'b1;
         fast_res_nxt = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         fast_q     <= 1'b0;
         fast_res_q <= '0;
      end else if (accept) begin
         fast_q     <= fast_nxt;
         fast_res_q <= fast_res_nxt;
      end
   end

   assign fast_o     = fast_q;
   assign fast_res_o = fast_res_q;
`else
   assign fast_o     = 1'b0;
   assign fast_res_o = '0;
`endif

endmodule

// File: tb/tb_muldiv_operand_stage.sv
// Randomised self-checking bench for muldiv_operand_stage, with a behavioural model and a handshake scoreboard.
// Expected fast-path results follow whether MULDIV_FASTPATH_EN is defined for this build.
module tb_muldiv_operand_stage;

`ifdef MULDIV_FASTPATH_EN
   localparam bit FP = 1'b1;
`else
   localparam bit FP = 1'b0;
`endif

   localparam logic [31:0] MIN32  = 32'h8000_0000;
   localparam logic [31:0] ONES32 = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset, kill, in_valid, out_ready;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        in_ready_o, out_valid_o, neg_res_o, div_sel_o, fast_o;
   logic [2:0]  op_o;
   logic [31:0] abs_a_o, abs_b_o, fast_res_o;
   logic [5:0]  status_o;

   logic        reset8, kill8, in_valid8, out_ready8;
   logic [2:0]  op8;
   logic [7:0]  a8, b8;
   logic        in_ready8, out_valid8, neg_res8, div_sel8, fast8;
   logic [2:0]  op_o8;
   logic [7:0]  abs_a8, abs_b8, fast_res8;
   logic [5:0]  status8;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   muldiv_operand_stage #(.XLEN(32)) u_dut (
      .clk_i(clk), .reset_i(reset), .kill_i(kill),
      .in_valid_i(in_valid), .in_ready_o(in_ready_o),
      .op_i(op), .a_i(a), .b_i(b),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready),
      .op_o(op_o), .abs_a_o(abs_a_o), .abs_b_o(abs_b_o),
      .neg_res_o(neg_res_o), .div_sel_o(div_sel_o), .status_o(status_o),
      .fast_o(fast_o), .fast_res_o(fast_res_o)
   );

   muldiv_operand_stage #(.XLEN(8)) u_dut8 (
      .clk_i(clk), .reset_i(reset8), .kill_i(kill8),
      .in_valid_i(in_valid8), .in_ready_o(in_ready8),
      .op_i(op8), .a_i(a8), .b_i(b8),
      .out_valid_o(out_valid8), .out_ready_i(out_ready8),
      .op_o(op_o8), .abs_a_o(abs_a8), .abs_b_o(abs_b8),
      .neg_res_o(neg_res8), .div_sel_o(div_sel8), .status_o(status8),
      .fast_o(fast8), .fast_res_o(fast_res8)
   );

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] abs_a;
      logic [31:0] abs_b;
      logic        neg;
      logic [5:0]  status;
      logic        fast;
      logic [31:0] fast_res;
   } exp_t;

   exp_t m_q;
   logic m_valid;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Arithmetic view of the operation: interpret operands, take magnitudes, decide trivial results.
   function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      bit is_div = (o >= 3'd4);
      bit a_s    = (o inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6});
      bit b_s    = (o inside {3'd0, 3'd1, 3'd4, 3'd6});
      bit a_n    = a_s && ($signed(x) < 0);
      bit b_n    = b_s && ($signed(y) < 0);
      e          = '0;
      e.op       = o;
      e.abs_a    = a_n ? (32'd0 - x) : x;
      e.abs_b    = b_n ? (32'd0 - y) : y;
      e.status   = {b_s && y == ONES32, y == 32'd1, y == 32'd0,
                    a_s && x == ONES32, x == 32'd1, x == 32'd0};
      if (is_div && y == 0)  e.neg = 1'b0;
      else if (o == 3'd6)    e.neg = a_n;
      else                   e.neg = (a_n != b_n);
      if (FP) begin
         if (is_div && y == 0) begin
            e.fast = 1'b1; e.fast_res = (o == 3'd4 || o == 3'd5) ? ONES32 : x;
         end else if ((o == 3'd4 || o == 3'd6) && x == MIN32 && y == ONES32) begin
            e.fast = 1'b1; e.fast_res = (o == 3'd4) ? MIN32 : 32'd0;
         end else if (o == 3'd0 && (x == 0 || y == 0)) begin
            e.fast = 1'b1; e.fast_res = 32'd0;
         end else if (o == 3'd0 && y == 1) begin
            e.fast = 1'b1; e.fast_res = x;
         end else if (o == 3'd0 && x == 1) begin
            e.fast = 1'b1; e.fast_res = y;
         end else if (o inside {3'd1, 3'd2, 3'd3} && (x == 0 || y == 0)) begin
            e.fast = 1'b1; e.fast_res = 32'd0;
         end
      end
      return e;
   endfunction

   // One clock: drive inputs, check ready, advance the scoreboard, then check registered outputs.
   task automatic cycle(input logic rst, input logic k, input logic v, input logic r,
                        input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      reset = rst; kill = k; in_valid = v; out_ready = r; op = o; a = x; b = y;
      #1;
      if (!rst) check("in_ready", in_ready_o, !m_valid || r);
      if (rst)                         begin m_valid = 1'b0; m_q = '0; end
      else if (k)                      m_valid = 1'b0;
      else if (v && (!m_valid || r))   begin m_valid = 1'b1; m_q = model(o, x, y); end
      else if (r)                      m_valid = 1'b0;
      @(posedge clk);
      #1;
      check("out_valid", out_valid_o, m_valid);
      if (m_valid || rst) begin
         check("op", op_o, m_q.op);
         check("abs_a", abs_a_o, m_q.abs_a);
         check("abs_b", abs_b_o, m_q.abs_b);
         check("neg_res", neg_res_o, m_q.neg);
         check("div_sel", div_sel_o, m_q.op[2]);
         check("status", status_o, m_q.status);
         check("fast", fast_o, m_q.fast);
         check("fast_res", fast_res_o, m_q.fast_res);
      end
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return ONES32;
         3:       return MIN32;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      m_valid = 1'b0;
      m_q     = '0;
      reset8 = 1'b1; kill8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1;
      op8 = 3'd0; a8 = 8'h00; b8 = 8'h00;

      cycle(1, 0, 0, 1, 3'd0, 32'd0, 32'd0);
      cycle(1, 0, 1, 1, 3'd4, 32'd7, 32'd0);
      check("rst_in_ready", in_ready_o, 1'b1);
      check("rst8_valid", out_valid8, 1'b0);
      reset8 = 1'b0;

      // DIV by zero
      cycle(0, 0, 1, 1, 3'd4, 32'd7, 32'd0);
      check("div0_fast", fast_o, FP);
      check("div0_res", fast_res_o, FP ? ONES32 : 32'd0);
      check("div0_B0", status_o[3], 1'b1);
      check("div0_neg", neg_res_o, 1'b0);

      // REM/REMU overflow corner
      cycle(0, 0, 1, 1, 3'd6, MIN32, ONES32);
      check("removf_fast", fast_o, FP);
      check("removf_res", fast_res_o, 32'd0);
      check("removf_Bm1", status_o[5], 1'b1);
      cycle(0, 0, 1, 1, 3'd7, MIN32, ONES32);
      check("remu_fast", fast_o, 1'b0);
      check("remu_Bm1", status_o[5], 1'b0);

      // DIV overflow and MUL identity
      cycle(0, 0, 1, 1, 3'd4, MIN32, ONES32);
      check("divovf_res", fast_res_o, FP ? MIN32 : 32'd0);
      cycle(0, 0, 1, 1, 3'd0, 32'd1, 32'h1234_5678);
      check("mul_a1_res", fast_res_o, FP ? 32'h1234_5678 : 32'd0);

      // MULH / MULHU magnitudes
      cycle(0, 0, 1, 1, 3'd1, 32'hFFFF_FFFB, 32'd3);
      check("mulh_abs_a", abs_a_o, 32'd5);
      check("mulh_abs_b", abs_b_o, 32'd3);
      check("mulh_neg", neg_res_o, 1'b1);
      check("mulh_fast", fast_o, 1'b0);
      cycle(0, 0, 1, 1, 3'd3, 32'hFFFF_FFFB, 32'd3);
      check("mulhu_abs_a", abs_a_o, 32'hFFFF_FFFB);
      check("mulhu_neg", neg_res_o, 1'b0);

      // Backpressure: entry held three cycles, then released
      cycle(0, 0, 1, 1, 3'd2, 32'hFFFF_FF00, 32'hFFFF_FFFF);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 1, 0, 3'd5, 32'd100, 32'd9);
         check("bp_in_ready", in_ready_o, 1'b0);
         check("bp_op_stable", op_o, 3'd2);
      end
      cycle(0, 0, 1, 1, 3'd5, 32'd100, 32'd9);
      check("bp_release_op", op_o, 3'd5);
      check("bp_release_valid", out_valid_o, 1'b1);

      // Kill while holding, with a same-cycle accepting input
      cycle(0, 0, 1, 0, 3'd0, 32'd3, 32'd4);
      cycle(0, 1, 1, 1, 3'd6, 32'd11, 32'd2);
      check("kill_valid", out_valid_o, 1'b0);
      cycle(0, 0, 0, 1, 3'd0, 32'd0, 32'd0);

      // XLEN=8 instance: MUL with a=1
      in_valid8 = 1'b1; op8 = 3'd0; a8 = 8'h01; b8 = 8'h9C;
      cycle(0, 0, 0, 1, 3'd0, 32'd0, 32'd0);
      in_valid8 = 1'b0;
      check("x8_valid", out_valid8, 1'b1);
      check("x8_fast", fast8, FP);
      check("x8_res", fast_res8, FP ? 8'h9C : 8'h00);
      check("x8_abs_b", abs_b8, 8'h64);
      check("x8_neg", neg_res8, 1'b1);
      check("x8_status", status8, 6'b000010);

      // Randomised traffic against the model
      for (int i = 0; i < 1500; i++) begin
         cycle($urandom_range(0, 99) == 0,
               $urandom_range(0, 19) == 0,
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 9) < 7,
               3'($urandom_range(0, 7)),
               pick_operand(), pick_operand());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
